// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MUL  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Execute-stage operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // ALUControl encoding of a multi-cycle multiply
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam int unsigned CNT_W = 4;

  // Forward select for one Execute source register; Memory wins over Writeback
  function automatic logic [1:0] fwd_sel(
    input logic       we_m,
    input logic [3:0] wa_m,
    input logic       we_w,
    input logic [3:0] wa_w,
    input logic [3:0] ra
  );
    if (we_m && (wa_m == ra))      return FWD_M;
    else if (we_w && (wa_w == ra)) return FWD_W;
    else                           return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_fwd.sv
// Combinational forwarding and data/PC hazard detection.
// FORWARDING_EN defined: forwarding muxes active, load-use stall.
// FORWARDING_EN undefined: no forwarding, RAW stall against E and M writers.
module hazard_fwd
  import pipeline_ctrl_pkg::*;
(
  input  logic [3:0] i_ra1d,
  input  logic [3:0] i_ra2d,
  input  logic [3:0] i_ra1e,
  input  logic [3:0] i_ra2e,
  input  logic [3:0] i_wa3e,
  input  logic [3:0] i_wa3m,
  input  logic [3:0] i_wa3w,
  input  logic       i_regwrite_e,
  input  logic       i_regwrite_m,
  input  logic       i_regwrite_w,
  input  logic       i_memtoreg_e,
  input  logic       i_pcsrc_d,
  input  logic       i_pcsrc_e,
  input  logic       i_pcsrc_m,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_hz_stall,
  output logic       o_pc_pend
);

  logic w_unused;

`ifdef FORWARDING_EN
  assign o_fwd_a    = fwd_sel(i_regwrite_m, i_wa3m, i_regwrite_w, i_wa3w, i_ra1e);
  assign o_fwd_b    = fwd_sel(i_regwrite_m, i_wa3m, i_regwrite_w, i_wa3w, i_ra2e);
  // Load result is not available for forwarding until after Memory
  assign o_hz_stall = i_memtoreg_e & ((i_wa3e == i_ra1d) | (i_wa3e == i_ra2d));
  assign w_unused   = i_regwrite_e;
`else
  assign o_fwd_a    = FWD_RF;
  assign o_fwd_b    = FWD_RF;
  // Without forwarding, any pending writer in E or M blocks a dependent decode
  assign o_hz_stall = (i_regwrite_e & ((i_wa3e == i_ra1d) | (i_wa3e == i_ra2d)))
                    | (i_regwrite_m & ((i_wa3m == i_ra1d) | (i_wa3m == i_ra2d)));
  assign w_unused   = ^{i_ra1e, i_ra2e, i_wa3w, i_regwrite_w, i_memtoreg_e};
`endif

  assign o_pc_pend = i_pcsrc_d | i_pcsrc_e | i_pcsrc_m;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stall/flush/forward generation, multiply
// occupancy counter and halt state. Optional feature macro: FORWARDING_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  input  logic       StuckW,
  input  logic       resume,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulBusy,
  output logic       Halted
);

  if ((MUL_CYCLES < 1) || (MUL_CYCLES > 15)) begin : g_bad_mul_cycles
    $error("pipeline_ctrl: MUL_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_CYCLES - 1);
  localparam bit               MUL_MULTI = (MUL_CYCLES > 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_mul_busy;
  logic             r_halted;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_hz_stall;
  logic       w_pc_pend;

  hazard_fwd u_hazard_fwd (
    .i_ra1d       (RA1D),
    .i_ra2d       (RA2D),
    .i_ra1e       (RA1E),
    .i_ra2e       (RA2E),
    .i_wa3e       (WA3E),
    .i_wa3m       (WA3M),
    .i_wa3w       (WA3W),
    .i_regwrite_e (RegWriteE),
    .i_regwrite_m (RegWriteM),
    .i_regwrite_w (RegWriteW),
    .i_memtoreg_e (MemtoRegE),
    .i_pcsrc_d    (PCSrcD),
    .i_pcsrc_e    (PCSrcE),
    .i_pcsrc_m    (PCSrcM),
    .o_fwd_a      (w_fwd_a),
    .o_fwd_b      (w_fwd_b),
    .o_hz_stall   (w_hz_stall),
    .o_pc_pend    (w_pc_pend)
  );

  // Sequencing FSM: multiply hold counter and halt, with registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_count    <= '0;
      r_mul_busy <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          // Stuck instruction is older than the multiply, so it wins
          if (StuckW) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (MulStartE && MUL_MULTI) begin
            r_state    <= MUL;
            r_count    <= MUL_LOAD;
            r_mul_busy <= 1'b1;
          end
        end
        MUL: begin
          if (r_count == CNT_W'(1)) begin
            r_state    <= RUN;
            r_count    <= '0;
            r_mul_busy <= 1'b0;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        HALT: begin
          if (resume) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state    <= RUN;
          r_count    <= '0;
          r_mul_busy <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  // Stall/flush muxing: hazard equations in RUN, full freeze in MUL and HALT
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = w_fwd_a;
    ForwardBE = w_fwd_b;
    case (r_state)
      RUN: begin
        StallF = w_hz_stall | w_pc_pend;
        StallD = w_hz_stall;
        FlushD = w_pc_pend | PCSrcW | BranchTakenE;
        FlushE = w_hz_stall | BranchTakenE;
      end
      MUL, HALT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end
      default: ;
    endcase
  end

  assign MulBusy = r_mul_busy;
  assign Halted  = r_halted;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two instances (MUL_CYCLES=3 and 1)
// share stimulus; directed scenarios plus randomized traffic against a model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic       MulStartE, StuckW, resume;

  logic       a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE, a_FlushM, a_MulBusy, a_Halted;
  logic [1:0] a_ForwardAE, a_ForwardBE;
  logic       b_StallF, b_StallD, b_StallE, b_FlushD, b_FlushE, b_FlushM, b_MulBusy, b_Halted;
  logic [1:0] b_ForwardAE, b_ForwardBE;

  pipeline_ctrl #(.MUL_CYCLES(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE), .StuckW(StuckW), .resume(resume),
    .StallF(a_StallF), .StallD(a_StallD), .StallE(a_StallE),
    .FlushD(a_FlushD), .FlushE(a_FlushE), .FlushM(a_FlushM),
    .ForwardAE(a_ForwardAE), .ForwardBE(a_ForwardBE),
    .MulBusy(a_MulBusy), .Halted(a_Halted)
  );

  pipeline_ctrl #(.MUL_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE), .StuckW(StuckW), .resume(resume),
    .StallF(b_StallF), .StallD(b_StallD), .StallE(b_StallE),
    .FlushD(b_FlushD), .FlushE(b_FlushE), .FlushM(b_FlushM),
    .ForwardAE(b_ForwardAE), .ForwardBE(b_ForwardBE),
    .MulBusy(b_MulBusy), .Halted(b_Halted)
  );

  // Packed view: {StallF,StallD,StallE,FlushD,FlushE,FlushM,FwdA,FwdB,MulBusy,Halted}
  logic [11:0] obs_a, obs_b;
  assign obs_a = {a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE, a_FlushM,
                  a_ForwardAE, a_ForwardBE, a_MulBusy, a_Halted};
  assign obs_b = {b_StallF, b_StallD, b_StallE, b_FlushD, b_FlushE, b_FlushM,
                  b_ForwardAE, b_ForwardBE, b_MulBusy, b_Halted};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remaining busy cycles and a halt flag per instance
  int unsigned m_n[2] = '{3, 1};
  int          m_left[2];
  bit          m_halt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0;
      m_halt[i] = 1'b0;
    end
  endtask

  function automatic logic [11:0] model_vec(input int i);
    logic [1:0] fa, fb;
    logic hz, pp, sf, sd, se, fd, fe, fm, busy;
    fa = 2'b00;
    fb = 2'b00;
`ifdef FORWARDING_EN
    if (RegWriteM && WA3M == RA1E) fa = 2'b10;
    else if (RegWriteW && WA3W == RA1E) fa = 2'b01;
    if (RegWriteM && WA3M == RA2E) fb = 2'b10;
    else if (RegWriteW && WA3W == RA2E) fb = 2'b01;
    hz = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
`else
    hz = (RegWriteE && (WA3E == RA1D || WA3E == RA2D)) ||
         (RegWriteM && (WA3M == RA1D || WA3M == RA2D));
`endif
    pp   = PCSrcD | PCSrcE | PCSrcM;
    busy = (m_left[i] > 0);
    if (m_halt[i] || busy) begin
      {sf, sd, se, fd, fe, fm} = 6'b111001;
    end else begin
      sf = hz | pp;
      sd = hz;
      se = 1'b0;
      fd = pp | PCSrcW | BranchTakenE;
      fe = hz | BranchTakenE;
      fm = 1'b0;
    end
    return {sf, sd, se, fd, fe, fm, fa, fb, busy, m_halt[i]};
  endfunction

  // Advance the model with the inputs the DUT samples, then move past the edge
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_left[i] = 0;
        m_halt[i] = 1'b0;
      end else if (m_halt[i]) begin
        if (resume) m_halt[i] = 1'b0;
      end else if (m_left[i] > 0) begin
        m_left[i] = m_left[i] - 1;
      end else if (StuckW) begin
        m_halt[i] = 1'b1;
      end else if (MulStartE && m_n[i] > 1) begin
        m_left[i] = int'(m_n[i]) - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    {MulStartE, StuckW, resume} = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (obs_a !== 12'h000) $display("FAIL reset_a got=%h want=%h", obs_a, 12'h000);
    else n_pass++;
    n_checks++;
    if (obs_b !== 12'h000) $display("FAIL reset_b got=%h want=%h", obs_b, 12'h000);
    else n_pass++;
    MulStartE = 1'b1;
    StuckW    = 1'b1;
    tick();
    n_checks++;
    if ({a_MulBusy, a_Halted} !== 2'b00)
      $display("FAIL reset_held got=%b want=00", {a_MulBusy, a_Halted});
    else n_pass++;
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] want_m, want_w;
`ifdef FORWARDING_EN
    want_m = 2'b10;
    want_w = 2'b01;
`else
    want_m = 2'b00;
    want_w = 2'b00;
`endif
    clear_inputs();
    RA1E = 4'd3; RA2E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1;
    n_checks++;
    if (a_ForwardAE !== want_m) $display("FAIL fwd_a_m got=%b want=%b", a_ForwardAE, want_m);
    else n_pass++;
    n_checks++;
    if (a_ForwardBE !== want_m) $display("FAIL fwd_b_m got=%b want=%b", a_ForwardBE, want_m);
    else n_pass++;
    RegWriteM = 1'b0;
    #1;
    n_checks++;
    if (a_ForwardAE !== want_w) $display("FAIL fwd_a_w got=%b want=%b", a_ForwardAE, want_w);
    else n_pass++;
    RA1E = 4'd4;
    #1;
    n_checks++;
    if (a_ForwardAE !== 2'b00) $display("FAIL fwd_a_none got=%b want=00", a_ForwardAE);
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    #1;
    n_checks++;
    if ({a_StallF, a_StallD, a_FlushE, a_StallE} !== 4'b1110)
      $display("FAIL load_use got=%b want=1110", {a_StallF, a_StallD, a_FlushE, a_StallE});
    else n_pass++;
    tick();
    RA2D = 4'd6;
    #1;
    n_checks++;
    if ({a_StallF, a_StallD, a_FlushE} !== 3'b000)
      $display("FAIL load_nouse got=%b want=000", {a_StallF, a_StallD, a_FlushE});
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_multiply();
    clear_inputs();
    MulStartE = 1'b1;
    tick();
    MulStartE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic want;
      want = (k < 2);
      #1;
      n_checks++;
      if ({a_MulBusy, a_StallE, a_FlushM, a_FlushD} !== {want, want, want, 1'b0})
        $display("FAIL mul3_cyc%0d got=%b want=%b", k,
                 {a_MulBusy, a_StallE, a_FlushM, a_FlushD}, {want, want, want, 1'b0});
      else n_pass++;
      n_checks++;
      if (b_MulBusy !== 1'b0) $display("FAIL mul1_cyc%0d got=%b want=0", k, b_MulBusy);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_halt();
    clear_inputs();
    StuckW = 1'b1;
    tick();
    StuckW = 1'b0;
    #1;
    n_checks++;
    if ({a_Halted, b_Halted, a_StallE, a_FlushM} !== 4'b1111)
      $display("FAIL halt_enter got=%b want=1111", {a_Halted, b_Halted, a_StallE, a_FlushM});
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if ({a_Halted, b_Halted} !== 2'b11)
        $display("FAIL halt_hold%0d got=%b want=11", k, {a_Halted, b_Halted});
      else n_pass++;
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    n_checks++;
    if ({a_Halted, b_Halted, a_StallE} !== 3'b000)
      $display("FAIL halt_exit got=%b want=000", {a_Halted, b_Halted, a_StallE});
    else n_pass++;
    StuckW = 1'b1;
    MulStartE = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if ({a_Halted, a_MulBusy} !== 2'b10)
      $display("FAIL halt_beats_mul got=%b want=10", {a_Halted, a_MulBusy});
    else n_pass++;
    tick();
    n_checks++;
    if (a_MulBusy !== 1'b0) $display("FAIL halt_no_mul got=%b want=0", a_MulBusy);
    else n_pass++;
    resume = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_mul();
    clear_inputs();
    MulStartE = 1'b1;
    tick();
    MulStartE = 1'b0;
    tick();
    n_checks++;
    if (a_MulBusy !== 1'b1) $display("FAIL mid_mul_busy got=%b want=1", a_MulBusy);
    else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({a_MulBusy, a_StallF, a_StallD, a_StallE, a_FlushM} !== 5'b00000)
      $display("FAIL async_reset got=%b want=00000",
               {a_MulBusy, a_StallF, a_StallD, a_StallE, a_FlushM});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    MulStartE = 1'b1;
    tick();
    MulStartE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic want;
      want = (k < 2);
      #1;
      n_checks++;
      if (a_MulBusy !== want) $display("FAIL post_reset_mul%0d got=%b want=%b", k, a_MulBusy, want);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchTakenE = 1'b1;
    #1;
    n_checks++;
    if ({a_FlushD, a_FlushE, b_FlushD, b_FlushE} !== 4'b1111)
      $display("FAIL branch_taken got=%b want=1111", {a_FlushD, a_FlushE, b_FlushD, b_FlushE});
    else n_pass++;
    clear_inputs();
    PCSrcM = 1'b1;
    #1;
    n_checks++;
    if ({a_StallF, a_FlushD, a_FlushE} !== 3'b110)
      $display("FAIL pcsrc_m got=%b want=110", {a_StallF, a_FlushD, a_FlushE});
    else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      PCSrcD = ($urandom_range(0, 5) == 0); PCSrcE = ($urandom_range(0, 5) == 0);
      PCSrcM = ($urandom_range(0, 5) == 0); PCSrcW = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      MulStartE = ($urandom_range(0, 4) == 0);
      StuckW    = ($urandom_range(0, 19) == 0);
      resume    = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++;
      if (obs_a !== model_vec(0)) $display("FAIL rand_a%0d got=%h want=%h", c, obs_a, model_vec(0));
      else n_pass++;
      n_checks++;
      if (obs_b !== model_vec(1)) $display("FAIL rand_b%0d got=%h want=%h", c, obs_b, model_vec(1));
      else n_pass++;
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_a !== model_vec(0)) $display("FAIL rand_rst%0d got=%h want=%h", c, obs_a, model_vec(0));
        else n_pass++;
        rst_n = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multiply();
    test_halt();
    test_reset_mid_mul();
    test_branch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
